// File: rtl/reg64_write_arbiter.sv
// reg64_write_arbiter
// Round-robin write arbiter for one shared WIDTH-bit register. The clients
// request writes, and one client wins per grant. The winner's data is loaded
// into the register, and a one-cycle ack pulse confirms the write.
// A GRANT cycle always follows each write, so at most one write completes
// every two cycles.
// Optional feature: define REG64_ARB_LOCK_EN to add the 'lock' input.
// With lock set, the current owner keeps winning while it holds req and lock.
// This allows atomic multi-word sequences.

module reg64_write_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 64,
  parameter int IDXW  = 2
) (
  input  logic                  clock,
  input  logic                  r,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] wdata,
`ifdef REG64_ARB_LOCK_EN
  input  logic [NREQ-1:0]       lock,
`endif
  output logic [NREQ-1:0]       ack,
  output logic [WIDTH-1:0]      q,
  output logic                  q_valid,
  output logic [IDXW-1:0]       owner,
  output logic                  busy
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0]       state_q,   state_d;
  logic [IDXW-1:0]  ptr_q,     ptr_d;
  logic [WIDTH-1:0] q_q,       q_d;
  logic             q_valid_q, q_valid_d;
  logic [IDXW-1:0]  owner_q,   owner_d;
  logic [NREQ-1:0]  ack_q,     ack_d;
  logic             busy_q,    busy_d;

  // Winner select: first requester after ptr, wrapping modulo NREQ
  logic [IDXW-1:0]  rr_idx;
  logic             rr_found;
  logic [IDXW-1:0]  cand_idx;
  logic [IDXW-1:0]  win_idx;
  logic             keep_ptr;

  // Round-robin search starting one past the last winner
  always_comb begin
    // NOTE: every combinationally assigned signal gets a default first,
    // so no path through the block leaves it unassigned (no latch).
    rr_idx   = '0;
    rr_found = 1'b0;
    cand_idx = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand_idx = IDXW'((int'(ptr_q) + i) % NREQ);
      if (!rr_found && req[cand_idx]) begin
        rr_found = 1'b1;
        rr_idx   = cand_idx;
      end
    end
  end

  // Lock bypass: a locked owner wins again without moving the pointer
  always_comb begin
    win_idx  = rr_idx;
    keep_ptr = 1'b0;
`ifdef REG64_ARB_LOCK_EN
    if (q_valid_q && req[owner_q] && lock[owner_q]) begin
      win_idx  = owner_q;
      keep_ptr = 1'b1;
    end
`endif
  end

  // Next-state logic for the IDLE/GRANT sequencer
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    q_d       = q_q;
    q_valid_d = q_valid_q;
    owner_d   = owner_q;
    ack_d     = '0;
    busy_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          q_d       = wdata[int'(win_idx)*WIDTH +: WIDTH];
          owner_d   = win_idx;
          ptr_d     = keep_ptr ? ptr_q : win_idx;
          q_valid_d = 1'b1;
          ack_d     = {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
          busy_d    = 1'b1;
          state_d   = GRANT;
        end
      end
      GRANT: begin
        // requests are ignored here; ack/busy fall at the next edge
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers, cleared asynchronously even in the middle of a GRANT
  always_ff @(posedge clock or negedge r) begin
    if (!r) begin
      state_q   <= IDLE;
      ptr_q     <= IDXW'(NREQ-1);
      q_q       <= '0;
      q_valid_q <= 1'b0;
      owner_q   <= '0;
      ack_q     <= '0;
      busy_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments, so all registers update together
      // from values sampled at the same edge.
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      q_q       <= q_d;
      q_valid_q <= q_valid_d;
      owner_q   <= owner_d;
      ack_q     <= ack_d;
      busy_q    <= busy_d;
    end
  end

  assign ack     = ack_q;
  assign q       = q_q;
  assign q_valid = q_valid_q;
  assign owner   = owner_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_reg64_write_arbiter.sv
// Directed bench for reg64_write_arbiter (NREQ=4, WIDTH=64).
// Define REG64_ARB_LOCK_EN to also exercise the lock feature.

module tb_reg64_write_arbiter;

  localparam logic [63:0] D0 = 64'h1000_0000_0000_00A0;
  localparam logic [63:0] D1 = 64'h2000_0000_0000_00B1;
  localparam logic [63:0] D2 = 64'hDEAD_BEEF_0000_0001;
  localparam logic [63:0] D3 = 64'h4000_0000_0000_00D3;

  logic         clk;
  logic         rst_n;
  logic [3:0]   req;
  logic [255:0] wdata;
  logic [3:0]   ack;
  logic [63:0]  q;
  logic         q_valid;
  logic [1:0]   owner;
  logic         busy;
`ifdef REG64_ARB_LOCK_EN
  logic [3:0]   lock;
`endif

  reg64_write_arbiter #(.NREQ(4), .WIDTH(64), .IDXW(2)) dut (
    .clock   (clk),
    .r       (rst_n),
    .req     (req),
    .wdata   (wdata),
`ifdef REG64_ARB_LOCK_EN
    .lock    (lock),
`endif
    .ack     (ack),
    .q       (q),
    .q_valid (q_valid),
    .owner   (owner),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [3:0]  req;
    logic [3:0]  ack;
    logic [1:0]  owner;
    logic [63:0] q;
    logic        qv;
    logic        busy;
  } vec_t;

  vec_t vecs [19];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // one clock, then settle just after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input vec_t v);
    check({tag, " ack"},     64'(ack),     64'(v.ack));
    check({tag, " owner"},   64'(owner),   64'(v.owner));
    check({tag, " q"},       q,            v.q);
    check({tag, " q_valid"}, 64'(q_valid), 64'(v.qv));
    check({tag, " busy"},    64'(busy),    64'(v.busy));
  endtask

  initial begin
    logic [1:0]  order [5];
    logic [63:0] dat   [4];
    logic [63:0] hold_q;
    logic [1:0]  hold_owner;

    dat[0] = D0; dat[1] = D1; dat[2] = D2; dat[3] = D3;
    order[0] = 2'd0; order[1] = 2'd1; order[2] = 2'd2; order[3] = 2'd3; order[4] = 2'd0;

    // {req, ack, owner, q, q_valid, busy}; starts from reset (ptr=3)
    vecs[0]  = '{4'b0000, 4'b0000, 2'd0, 64'h0, 1'b0, 1'b0};
    vecs[1]  = '{4'b0100, 4'b0100, 2'd2, D2,    1'b1, 1'b1};
    vecs[2]  = '{4'b0000, 4'b0000, 2'd2, D2,    1'b1, 1'b0};
    vecs[3]  = '{4'b0000, 4'b0000, 2'd2, D2,    1'b1, 1'b0};
    vecs[4]  = '{4'b1111, 4'b1000, 2'd3, D3,    1'b1, 1'b1};
    vecs[5]  = '{4'b1111, 4'b0000, 2'd3, D3,    1'b1, 1'b0};
    vecs[6]  = '{4'b1111, 4'b0001, 2'd0, D0,    1'b1, 1'b1};
    vecs[7]  = '{4'b1111, 4'b0000, 2'd0, D0,    1'b1, 1'b0};
    vecs[8]  = '{4'b1111, 4'b0010, 2'd1, D1,    1'b1, 1'b1};
    vecs[9]  = '{4'b1111, 4'b0000, 2'd1, D1,    1'b1, 1'b0};
    vecs[10] = '{4'b1111, 4'b0100, 2'd2, D2,    1'b1, 1'b1};
    vecs[11] = '{4'b1111, 4'b0000, 2'd2, D2,    1'b1, 1'b0};
    vecs[12] = '{4'b1111, 4'b1000, 2'd3, D3,    1'b1, 1'b1};
    vecs[13] = '{4'b1111, 4'b0000, 2'd3, D3,    1'b1, 1'b0};
    vecs[14] = '{4'b0011, 4'b0001, 2'd0, D0,    1'b1, 1'b1};
    vecs[15] = '{4'b0011, 4'b0000, 2'd0, D0,    1'b1, 1'b0};
    vecs[16] = '{4'b0011, 4'b0010, 2'd1, D1,    1'b1, 1'b1};
    vecs[17] = '{4'b0000, 4'b0000, 2'd1, D1,    1'b1, 1'b0};
    vecs[18] = '{4'b0000, 4'b0000, 2'd1, D1,    1'b1, 1'b0};

    wdata = {D3, D2, D1, D0};
    req   = 4'b1111;
`ifdef REG64_ARB_LOCK_EN
    lock  = 4'b0000;
`endif
    rst_n = 1'b1;
    #1 rst_n = 1'b0;

    // reset held 3 cycles with all clients requesting
    repeat (3) step();
    check_all("reset", '{4'b1111, 4'b0000, 2'd0, 64'h0, 1'b0, 1'b0});

    // release away from a clock edge, requests still held: order 0,1,2,3,0
    #2 rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      if (c % 2 == 0) begin
        check($sformatf("rr%0d ack", c), 64'(ack), 64'(4'b0001 << order[c/2]));
        check($sformatf("rr%0d q", c), q, dat[order[c/2]]);
        check($sformatf("rr%0d busy", c), 64'(busy), 64'd1);
      end else begin
        check($sformatf("rr%0d ack", c), 64'(ack), 64'd0);
        check($sformatf("rr%0d busy", c), 64'(busy), 64'd0);
      end
    end

    // reset asserted in the middle of a GRANT clears everything at once
    step();
    check("pre-reset ack", 64'(ack), 64'(4'b0010));
    rst_n = 1'b0;
    #1;
    check_all("midgrant", '{4'b1111, 4'b0000, 2'd0, 64'h0, 1'b0, 1'b0});
    req = 4'b0000;
    #2 rst_n = 1'b1;

    // table-driven vectors
    for (int i = 0; i < 19; i++) begin
      req = vecs[i].req;
      step();
      check_all($sformatf("vec%0d", i), vecs[i]);
    end

    // idle hold: nothing changes for 20 cycles without requests
    hold_q     = q;
    hold_owner = owner;
    req = 4'b0000;
    for (int c = 0; c < 20; c++) begin
      step();
      check($sformatf("idle%0d ack", c), 64'(ack), 64'd0);
      check($sformatf("idle%0d q", c), q, D1);
      check($sformatf("idle%0d owner", c), 64'(owner), 64'(hold_owner));
      check($sformatf("idle%0d q_valid", c), 64'(q_valid), 64'd1);
    end
    check("idle q unchanged", q, hold_q);

`ifdef REG64_ARB_LOCK_EN
    // owner=1, ptr=1; client 1 locked while client 2 also requests
    req  = 4'b0110;
    lock = 4'b0010;
    for (int c = 0; c < 5; c++) begin
      step();
      check($sformatf("lock%0d ack", c), 64'(ack), (c % 2 == 0) ? 64'(4'b0010) : 64'd0);
    end
    lock = 4'b0000;
    step();
    check("unlock grant-cycle ack", 64'(ack), 64'd0);
    step();
    check("unlock ack", 64'(ack), 64'(4'b0100));
    check("unlock owner", 64'(owner), 64'd2);
    check("unlock q", q, D2);
    req = 4'b0000;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg64_write_arbiter.md
Name: reg64_write_arbiter

Overview:
- Round-robin write arbiter and sequencer for one shared 64-bit storage register.
- Up to NREQ clients request writes; the arbiter grants one client at a time and loads its data into the internal register.
- Each grant is acknowledged with a one-cycle pulse. The register contents stay readable continuously.
- Sits between game-logic producers (CPU writeback, input sampler, timer, VGA status) and the shared game-state word.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 64, data width of the shared register.
- IDXW, 2, width of owner index; must equal ceil(log2(NREQ)).

Ports:
- clock  input  1  system clock, rising edge.
- r  input  1  reset, asynchronous, active-low.
- req  input  NREQ  per-client write request; held high until ack is seen.
- wdata  input  NREQ*WIDTH  client i data in slice [i*WIDTH +: WIDTH]; stable while req[i] is high.
- ack  output  NREQ  one-hot, one-cycle write-complete pulse.
- q  output  WIDTH  current register contents.
- q_valid  output  1  high once any write has completed.
- owner  output  IDXW  index of the last client written.
- busy  output  1  high while in GRANT.

Behaviour:
- Reset: asserting r low immediately clears the following, regardless of clock, including mid-GRANT:
  - q=0, q_valid=0, ack=0, owner=0, busy=0.
  - state=IDLE, round-robin pointer ptr=NREQ-1.
- States: IDLE, GRANT.
- IDLE, at a clock edge with any req bit high:
  - Winner = first i with req[i]=1, searching ptr+1, ptr+2, … modulo NREQ.
  - Same edge: q <= winner's wdata slice; owner <= winner; ptr <= winner; q_valid <= 1; state <= GRANT.
- IDLE with no req: hold all state. ack stays 0.
- GRANT, which always lasts exactly one cycle:
  - ack[owner]=1 and busy=1 for the whole cycle; all req inputs are ignored.
  - Next edge: state <= IDLE, ack <= 0.
- Latency:
  - q reflects new data the cycle after the request is sampled.
  - ack is visible in that same cycle.
- Throughput: at most one write per 2 cycles.
- Client protocol:
  - After seeing ack[i], the client deasserts req[i] at the next edge, or keeps it high to request another write.
  - A held req re-competes in the next IDLE cycle with rotated priority.
- Fairness: a client that has just won has lowest priority next time, so each requester waits at most NREQ grants.
- Simultaneous requests: exactly one winner per grant; all others remain pending and receive no ack.
- Pointer wraps from NREQ-1 to 0.
- q holds its value indefinitely between writes. No read handshake; q is always valid when q_valid=1.
- No combinational path from req/wdata to any output: ack, owner, busy, q and q_valid are all registered.

Optional Feature:
- Macro: REG64_ARB_LOCK_EN.
- Defined:
  - Extra input port lock, NREQ bits.
  - In IDLE, if req[owner] and lock[owner] are both high and q_valid=1, owner wins unconditionally, bypassing round-robin.
  - ptr unchanged, so atomic multi-word sequences are possible.
  - Lock is released when lock[owner] drops.
- Undefined: no lock port; pure round-robin as above.

Test Plan:
- Reset: hold r=0 for 3 cycles with req=4'b1111 -> q=0, q_valid=0, ack=0, busy=0. Assert r=0 mid-GRANT -> ack drops to 0 without waiting for a clock edge.
- Single write: req=4'b0100, wdata[2]=64'hDEAD_BEEF_0000_0001 -> next cycle: q=64'hDEAD_BEEF_0000_0001, owner=2, ack=4'b0100 for exactly 1 cycle, q_valid=1.
- Round-robin: req=4'b1111 held continuously from reset -> ack order 0,1,2,3,0, one every 2 cycles. Each q equals the winning slice.
- Skip and wrap: after a grant to client 3, req=4'b0011 -> client 0 granted first, then client 1.
- Idle hold: no req for 20 cycles after a write -> q, owner and q_valid unchanged; ack=0 throughout.
- Lock (REG64_ARB_LOCK_EN): client 1 holds req=1, lock=1 while client 2 also requests -> client 1 granted 3 times in a row. After lock[1]=0, the next grant goes to client 2.
